// File: rtl/spike_rate_encoder.sv
// Rate-coded spike generator: four 4-bit intensities compared against LFSR nibbles per timestep.
// Optional refractory masking is enabled by defining SPIKE_ENCODER_REFRACTORY_EN.
module spike_rate_encoder #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] intensity,
  input  logic [3:0]  window,
  output logic [3:0]  spikes,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic        last,
  output logic        busy,
  output logic        done,
  output logic [6:0]  spike_total
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [7:0]         lfsr;
  logic [15:0]        int_lat;
  logic [3:0]         win_lat;
  logic [3:0]         step;
  logic [3:0][3:0]    nib;
  logic [3:0]         raw;
  logic [3:0]         gated;
  logic               transfer;
  logic               accept;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign nib[0]   = lfsr[3:0];
  assign nib[1]   = lfsr[7:4];
  assign nib[2]   = lfsr[3:0] ^ lfsr[7:4];
  assign nib[3]   = {lfsr[0], lfsr[7:5]};
  assign accept   = (state == IDLE) && start;
  assign transfer = spike_valid && spike_ready;

  always_comb begin
    raw = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      raw[n] = int_lat[4*n +: 4] > nib[n];
    end
  end

`ifdef SPIKE_ENCODER_REFRACTORY_EN
  logic [3:0] refractory;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refractory <= '0;
    end else if (accept) begin
      refractory <= '0;
    end else if (transfer) begin
      refractory <= spikes;
    end
  end

  assign gated = raw & ~refractory;
`else
  assign gated = raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (transfer && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window length 0 means 16 steps: the 4-bit subtraction wraps to 15.
  always_comb begin
    spike_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    last        = 1'b0;
    spikes      = '0;
    unique case (state)
      RUN: begin
        spike_valid = 1'b1;
        busy        = 1'b1;
        last        = (step == win_lat - 4'd1);
        spikes      = gated;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= SEED_EFF;
      int_lat     <= '0;
      win_lat     <= '0;
      step        <= '0;
      spike_total <= '0;
    end else if (accept) begin
      int_lat     <= intensity;
      win_lat     <= window;
      step        <= '0;
      spike_total <= '0;
    end else if (transfer) begin
      lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      step        <= step + 4'd1;
      spike_total <= spike_total + 7'(popcount4(spikes));
    end
  end

endmodule
